lcd_hd44780_ctrl: RTL
=====================

# lcd_hd44780_ctrl

Parametrised HD44780 character-LCD controller: second-generation display driver for the MIPS system's memory-mapped LCD port. It accepts a valid/ready request stream (write char, set cursor, clear, raw command), generates timed RS/EN/DATA cycles with programmable pulse width and settle times, and tracks the cursor position for any ROWS x COLS panel (1–4 rows). It runs directly on the system clock; no external clock divider is needed.

## Interface
- ROWS, 2, panel rows, 1..4
- COLS, 16, panel columns, 1..40
- PWRUP_CYCLES, 750000, wait after reset before the first init command
- EN_CYCLES, 16, clocks LCD_EN is held high per transfer
- WAIT_CYCLES, 2500, settle clocks after EN falls, normal commands
- CLEAR_WAIT_CYCLES, 82000, settle clocks after clear (0x01)
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_cmd  in  2  00 write char, 01 set cursor, 10 clear, 11 raw command
- req_data  in  8  character code (00) or raw command byte (11)
- req_row  in  2  target row (01)
- req_col  in  6  target column (01)
- done  out  1  one-cycle pulse when a request completes
- init_done  out  1  high after the init sequence completes
- cur_row  out  2  current cursor row
- cur_col  out  6  current cursor column
- LCD_ON, LCD_BLON, LCD_RW  out  1 each  constant 1, 0, 0
- LCD_EN  out  1  LCD strobe
- LCD_RS  out  1  0 command, 1 data
- LCD_DATA  out  8  bus value

## Operation
- States: PWRUP, INIT, IDLE, ISSUE, EN_HIGH, SETTLE. One 20-bit down-counter serves all waits.
- Reset values: LCD_EN=0, LCD_RS=0, LCD_DATA=0x00, req_ready=0, done=0, init_done=0, cur_row=0, cur_col=0. State is PWRUP.
- PWRUP: wait PWRUP_CYCLES, then enter INIT.
- INIT: issue the fixed sequence 0x38, 0x0C, 0x01, 0x06. Each byte goes through ISSUE, EN_HIGH and SETTLE. After 0x06, set init_done=1 and enter IDLE.
- IDLE: req_ready=1. A transfer occurs when req_valid && req_ready; the request fields are latched and req_ready drops next cycle.
- Command mapping:
  - write char: RS=1, DATA=req_data.
  - set cursor: RS=0, DATA=0x80|addr. Row addresses are 0x00, 0x40, COLS, 0x40+COLS. Out-of-range row/col are clamped to ROWS-1/COLS-1.
  - clear: RS=0, DATA=0x01, cursor set to 0,0, settle uses CLEAR_WAIT_CYCLES.
  - raw: RS=0, DATA=req_data. The cursor is not tracked for raw commands.
- Cursor update happens on completion:
  - write char: cur_col+1.
  - set cursor: loads the clamped row/col.

## Timing
- ISSUE: 1 cycle. RS and DATA are driven, EN=0 (setup time).
- EN_HIGH: EN=1 for EN_CYCLES cycles. RS and DATA stay stable.
- SETTLE: EN=0 for WAIT_CYCLES cycles (CLEAR_WAIT_CYCLES for 0x01). RS and DATA hold.
- A single bus transfer takes 1+EN_CYCLES+settle cycles.
- done pulses in the first IDLE cycle after the last transfer of the request. req_ready is 1 in that same cycle, so a back-to-back accept there is legal.
- req_valid seen during PWRUP/INIT is ignored (ready=0). The request must stay held.
- Reset mid-transfer: immediate return to reset values. Any partial request is dropped and the full PWRUP+INIT sequence is repeated.

## Configuration
- LCD_AUTOWRAP_EN defined:
  - A char write at cur_col=COLS-1 completes, then an internal set-cursor transfer is issued to (cur_row+1 mod ROWS, 0).
  - done pulses only after that second transfer.
- LCD_AUTOWRAP_EN undefined:
  - cur_col wraps to 0 modulo COLS, cur_row is unchanged, and no extra transfer is issued.

## Test plan
All scenarios use PWRUP=10, EN=2, WAIT=4, CLEAR_WAIT=8 (2x16 panel unless stated).
- Reset release: EN low 10 cycles, then bytes 0x38, 0x0C, 0x01, 0x06 with RS=0. Each EN pulse is 2 cycles wide. The gap after 0x01 is 8 cycles. init_done=1 and req_ready=1 afterwards.
- Char write 0x41: one transfer with RS=1, DATA=0x41, EN high 2 cycles. done pulses 7 cycles after accept. cur_col 0→1.
- Set cursor row=1 col=5: DATA=0xC5, RS=0. cur_row=1, cur_col=5. Out-of-range col=50 gives DATA=0xCF.
- 4x20 panel, set cursor row=2 col=0: DATA=0x94. Clear gives DATA=0x01, an 8-cycle settle and cursor 0,0.
- Write at col 15, row 0: with LCD_AUTOWRAP_EN, the char transfer is followed by DATA=0xC0, then done, cursor 1,0. Without it, done follows the single transfer and the cursor is 0,0.
- Reset asserted during EN_HIGH of a char write: LCD_EN=0 and DATA=0x00 immediately. No done. Init sequence repeats.

Source files
------------

// File: rtl/lcd_hd44780_ctrl_if.sv
// Request stream into the HD44780 controller: a valid/ready handshake
// plus the command fields that are latched when a transfer occurs.
interface lcd_hd44780_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_cmd;
  logic [7:0] req_data;
  logic [1:0] req_row;
  logic [5:0] req_col;

  modport master (output req_valid, req_cmd, req_data, req_row, req_col,
                  input  req_ready);
  modport slave  (input  req_valid, req_cmd, req_data, req_row, req_col,
                  output req_ready);
endinterface

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character-LCD controller running on the system clock.
// Power-up wait, fixed init sequence, then request-driven transfers with
// programmable EN pulse width and settle times; tracks the cursor for a
// ROWS x COLS panel. Optional feature: LCD_AUTOWRAP_EN moves the cursor
// to the start of the next row after a write in the last column.
module lcd_hd44780_ctrl #(
  parameter int ROWS              = 2,
  parameter int COLS              = 16,
  parameter int PWRUP_CYCLES      = 750000,
  parameter int EN_CYCLES         = 16,
  parameter int WAIT_CYCLES       = 2500,
  parameter int CLEAR_WAIT_CYCLES = 82000
) (
  input  logic                 clock,
  input  logic                 reset,
  lcd_hd44780_ctrl_if.slave    req,
  output logic                 done,
  output logic                 init_done,
  output logic [1:0]           cur_row,
  output logic [5:0]           cur_col,
  output logic                 LCD_ON,
  output logic                 LCD_BLON,
  output logic                 LCD_RW,
  output logic                 LCD_EN,
  output logic                 LCD_RS,
  output logic [7:0]           LCD_DATA
);

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, ISSUE, EN_HIGH, SETTLE} state_t;

  // Latched request; wrap marks the internal follow-up set-cursor transfer.
  typedef struct packed {
    logic [1:0] cmd;
    logic [1:0] row;
    logic [5:0] col;
    logic       wrap;
  } job_t;

  localparam logic [1:0]  CMD_CHAR = 2'b00;
  localparam logic [1:0]  CMD_CUR  = 2'b01;
  localparam logic [1:0]  CMD_CLR  = 2'b10;

  localparam logic [19:0] PWRUP_L  = 20'(PWRUP_CYCLES - 1);
  localparam logic [19:0] EN_L     = 20'(EN_CYCLES - 1);
  localparam logic [19:0] WAIT_L   = 20'(WAIT_CYCLES - 1);
  localparam logic [19:0] CLR_L    = 20'(CLEAR_WAIT_CYCLES - 1);
  localparam logic [1:0]  ROW_MAX  = 2'(ROWS - 1);
  localparam logic [5:0]  COL_MAX  = 6'(COLS - 1);
  localparam logic [6:0]  COLS_A   = 7'(COLS);

  // DDRAM set-address command for a row/column pair.
  function automatic logic [7:0] cur_byte(input logic [1:0] r, input logic [5:0] c);
    logic [6:0] base;
    case (r)
      2'd0:    base = 7'h00;
      2'd1:    base = 7'h40;
      2'd2:    base = COLS_A;
      default: base = 7'h40 + COLS_A;
    endcase
    return {1'b1, base + {1'b0, c}};
  endfunction

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  job_t        job_q;
  logic [1:0]  init_idx;

  logic        ld, ld_rs, accept, fin, wrap_go, init_adv, init_fin;
  logic [7:0]  ld_data;
  logic        rq_rs, wrap_need, is_clr;
  logic [7:0]  rq_byte;
  logic [1:0]  rq_row, next_row;
  logic [5:0]  rq_col;

  assign req.req_ready = (state_q == IDLE);
  assign LCD_EN        = (state_q == EN_HIGH);
  assign LCD_ON        = 1'b1;
  assign LCD_BLON      = 1'b0;
  assign LCD_RW        = 1'b0;

  assign rq_row   = (req.req_row > ROW_MAX) ? ROW_MAX : req.req_row;
  assign rq_col   = (req.req_col > COL_MAX) ? COL_MAX : req.req_col;
  assign next_row = (cur_row == ROW_MAX) ? 2'd0 : cur_row + 2'd1;
  assign is_clr   = !LCD_RS && (LCD_DATA == 8'h01);

`ifdef LCD_AUTOWRAP_EN
  assign wrap_need = (job_q.cmd == CMD_CHAR) && !job_q.wrap && (cur_col == COL_MAX);
`else
  assign wrap_need = 1'b0;
`endif

  // Bus byte and RS for the incoming request.
  always_comb begin
    rq_rs   = 1'b0;
    rq_byte = req.req_data;
    case (req.req_cmd)
      CMD_CHAR: rq_rs   = 1'b1;
      CMD_CUR:  rq_byte = cur_byte(rq_row, rq_col);
      CMD_CLR:  rq_byte = 8'h01;
      default:  ;
    endcase
  end

  // State and shared wait counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= PWRUP;
      cnt_q   <= PWRUP_L;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter reloads and datapath strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ld       = 1'b0;
    ld_rs    = 1'b0;
    ld_data  = 8'h00;
    accept   = 1'b0;
    fin      = 1'b0;
    wrap_go  = 1'b0;
    init_adv = 1'b0;
    init_fin = 1'b0;
    case (state_q)
      PWRUP:
        if (cnt_q == 20'd0) state_d = INIT;
        else                cnt_d   = cnt_q - 20'd1;
      INIT: begin
        ld      = 1'b1;
        ld_data = init_byte(init_idx);
        state_d = ISSUE;
      end
      IDLE:
        if (req.req_valid) begin
          accept  = 1'b1;
          ld      = 1'b1;
          ld_rs   = rq_rs;
          ld_data = rq_byte;
          state_d = ISSUE;
        end
      ISSUE: begin
        cnt_d   = EN_L;
        state_d = EN_HIGH;
      end
      EN_HIGH:
        if (cnt_q == 20'd0) begin
          cnt_d   = is_clr ? CLR_L : WAIT_L;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      SETTLE:
        if (cnt_q != 20'd0) begin
          cnt_d = cnt_q - 20'd1;
        end else if (!init_done) begin
          if (init_idx == 2'd3) begin
            init_fin = 1'b1;
            state_d  = IDLE;
          end else begin
            init_adv = 1'b1;
            ld       = 1'b1;
            ld_data  = init_byte(init_idx + 2'd1);
            state_d  = ISSUE;
          end
        end else if (wrap_need) begin
          wrap_go = 1'b1;
          ld      = 1'b1;
          ld_data = cur_byte(next_row, 6'd0);
          state_d = ISSUE;
        end else begin
          fin     = 1'b1;
          state_d = IDLE;
        end
      default: state_d = PWRUP;
    endcase
  end

  // Bus registers, request latch, init progress and cursor tracking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      LCD_RS    <= 1'b0;
      LCD_DATA  <= 8'h00;
      done      <= 1'b0;
      init_done <= 1'b0;
      init_idx  <= 2'd0;
      cur_row   <= 2'd0;
      cur_col   <= 6'd0;
      job_q     <= '0;
    end else begin
      done <= fin;
      if (ld) begin
        LCD_RS   <= ld_rs;
        LCD_DATA <= ld_data;
      end
      if (accept)
        job_q <= '{cmd: req.req_cmd, row: rq_row, col: rq_col, wrap: 1'b0};
      if (wrap_go) begin
        job_q.wrap <= 1'b1;
        job_q.row  <= next_row;
        job_q.col  <= 6'd0;
      end
      if (init_adv) init_idx  <= init_idx + 2'd1;
      if (init_fin) init_done <= 1'b1;
      if (fin) begin
        if (job_q.wrap || job_q.cmd == CMD_CUR) begin
          cur_row <= job_q.row;
          cur_col <= job_q.col;
        end else if (job_q.cmd == CMD_CHAR) begin
          cur_col <= (cur_col == COL_MAX) ? 6'd0 : cur_col + 6'd1;
        end else if (job_q.cmd == CMD_CLR) begin
          cur_row <= 2'd0;
          cur_col <= 6'd0;
        end
      end
    end
  end

endmodule
